// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// datapath select codes and the per-state control word decode.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE  = 4'd0,
        CL_R     = 4'd1,
        CL_I     = 4'd2,
        CL_LW    = 4'd3,
        CL_SW    = 4'd4,
        CL_BR    = 4'd5,
        CL_JAL   = 4'd6,
        CL_JALR  = 4'd7,
        CL_LUI   = 4'd8,
        CL_AUIPC = 4'd9
    } op_class_e;

    typedef enum logic [1:0] {
        SRC_A_PC   = 2'b00,
        SRC_A_RS1  = 2'b01,
        SRC_A_ZERO = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        alu_src_a_e alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        wb_sel_e    wb_sel;
    } ctrl_t;

    // Control word for a state, given the class latched in DECODE.
    function automatic ctrl_t ctrl_decode(input state_e st, input op_class_e cls);
        ctrl_t c;
        c.mem_req   = 1'b0;
        c.mem_we    = 1'b0;
        c.iord      = 1'b0;
        c.pc_write  = 1'b0;
        c.branch    = 1'b0;
        c.reg_write = 1'b0;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_ADD;
        c.wb_sel    = WB_ALU;
        case (st)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: begin
                c.alu_src_b = SRC_B_IMM;
            end
            ST_EXEC: begin
                case (cls)
                    CL_R: begin
                        c.alu_src_a = SRC_A_RS1;
                        c.alu_op    = ALU_FUNCT;
                    end
                    CL_I: begin
                        c.alu_src_a = SRC_A_RS1;
                        c.alu_src_b = SRC_B_IMM;
                        c.alu_op    = ALU_FUNCT;
                    end
                    CL_LW, CL_SW: begin
                        c.alu_src_a = SRC_A_RS1;
                        c.alu_src_b = SRC_B_IMM;
                    end
                    CL_BR: begin
                        c.alu_src_a = SRC_A_RS1;
                        c.alu_op    = ALU_BRANCH;
                        c.branch    = 1'b1;
                    end
                    CL_JAL: begin
                        c.alu_src_b = SRC_B_IMM;
                        c.pc_write  = 1'b1;
                    end
                    CL_JALR: begin
                        c.alu_src_a = SRC_A_RS1;
                        c.alu_src_b = SRC_B_IMM;
                        c.pc_write  = 1'b1;
                    end
                    CL_LUI: begin
                        c.alu_src_a = SRC_A_ZERO;
                        c.alu_src_b = SRC_B_IMM;
                    end
                    CL_AUIPC: begin
                        c.alu_src_b = SRC_B_IMM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (cls == CL_SW);
            end
            ST_WB: begin
                c.reg_write = 1'b1;
                if (cls == CL_LW)
                    c.wb_sel = WB_MEM;
                else if (cls == CL_JAL || cls == CL_JALR)
                    c.wb_sel = WB_PC4;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Maps a 7-bit opcode to its instruction class; jump/upper-immediate
// opcodes only decode when EXT_J is set.
module opcode_class_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit EXT_J = 1'b1
) (
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CL_NONE;
        case (opcode)
            OP_R:     op_class = CL_R;
            OP_I:     op_class = CL_I;
            OP_LW:    op_class = CL_LW;
            OP_SW:    op_class = CL_SW;
            OP_BR:    op_class = CL_BR;
            OP_JAL:   if (EXT_J) op_class = CL_JAL;
            OP_JALR:  if (EXT_J) op_class = CL_JALR;
            OP_LUI:   if (EXT_J) op_class = CL_LUI;
            OP_AUIPC: if (EXT_J) op_class = CL_AUIPC;
            default:  op_class = CL_NONE;
        endcase
    end

    assign legal = (op_class != CL_NONE);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// with a memory wait timeout and a sticky trap.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_FETCH  | instruction read from PC; waits for mem_ready
//   ST_DECODE | opcode classified and latched; illegal opcodes trap
//   ST_EXEC   | ALU operation, branch or jump for the latched class
//   ST_MEM    | data access at ALU result (LW read, SW write)
//   ST_WB     | one-cycle register file write
//   ST_TRAP   | absorbing error state, left only by reset
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit EXT_J       = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // Down-counter reload: the terminal count of zero is the last allowed wait cycle.
    localparam logic [7:0] WAIT_LOAD = 8'(MEM_TIMEOUT - 1);

    state_e      state_q;
    op_class_e   class_q;
    logic [7:0]  wait_cnt_q;
    logic        trap_q;
    trap_cause_e trap_cause_q;
    ctrl_t       ctrl_q;

    op_class_e   dec_class;
    logic        dec_legal;

    opcode_class_decoder #(
        .EXT_J (EXT_J)
    ) u_decoder (
        .opcode   (opcode),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FETCH;
            class_q      <= CL_NONE;
            wait_cnt_q   <= WAIT_LOAD;
            trap_q       <= 1'b0;
            trap_cause_q <= CAUSE_NONE;
            ctrl_q       <= ctrl_decode(ST_FETCH, CL_NONE);
        end else begin
            case (state_q)
                ST_FETCH, ST_MEM: begin
                    if (mem_ready) begin
                        if (state_q == ST_FETCH) begin
                            state_q <= ST_DECODE;
                            ctrl_q  <= ctrl_decode(ST_DECODE, class_q);
                        end else if (class_q == CL_LW) begin
                            state_q <= ST_WB;
                            ctrl_q  <= ctrl_decode(ST_WB, class_q);
                        end else begin
                            state_q    <= ST_FETCH;
                            wait_cnt_q <= WAIT_LOAD;
                            ctrl_q     <= ctrl_decode(ST_FETCH, class_q);
                        end
                    end else if (wait_cnt_q == 8'd0) begin
                        state_q      <= ST_TRAP;
                        trap_q       <= 1'b1;
                        trap_cause_q <= CAUSE_TIMEOUT;
                        ctrl_q       <= ctrl_decode(ST_TRAP, class_q);
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 8'd1;
                    end
                end
                ST_DECODE: begin
                    class_q <= dec_class;
                    if (dec_legal) begin
                        state_q <= ST_EXEC;
                        ctrl_q  <= ctrl_decode(ST_EXEC, dec_class);
                    end else begin
                        state_q      <= ST_TRAP;
                        trap_q       <= 1'b1;
                        trap_cause_q <= CAUSE_ILLEGAL;
                        ctrl_q       <= ctrl_decode(ST_TRAP, dec_class);
                    end
                end
                ST_EXEC: begin
                    case (class_q)
                        CL_LW, CL_SW: begin
                            state_q    <= ST_MEM;
                            wait_cnt_q <= WAIT_LOAD;
                            ctrl_q     <= ctrl_decode(ST_MEM, class_q);
                        end
                        CL_BR: begin
                            state_q    <= ST_FETCH;
                            wait_cnt_q <= WAIT_LOAD;
                            ctrl_q     <= ctrl_decode(ST_FETCH, class_q);
                        end
                        CL_NONE: begin
                            state_q      <= ST_TRAP;
                            trap_q       <= 1'b1;
                            trap_cause_q <= CAUSE_ILLEGAL;
                            ctrl_q       <= ctrl_decode(ST_TRAP, class_q);
                        end
                        default: begin
                            state_q <= ST_WB;
                            ctrl_q  <= ctrl_decode(ST_WB, class_q);
                        end
                    endcase
                end
                ST_WB: begin
                    state_q    <= ST_FETCH;
                    wait_cnt_q <= WAIT_LOAD;
                    ctrl_q     <= ctrl_decode(ST_FETCH, class_q);
                end
                ST_TRAP: ;
                default: begin
                    state_q    <= ST_FETCH;
                    wait_cnt_q <= WAIT_LOAD;
                    ctrl_q     <= ctrl_decode(ST_FETCH, CL_NONE);
                end
            endcase
        end
    end

    // The fetch handshake has to load IR/PC in the mem_ready cycle itself,
    // so it is the one enable qualified by an input; the phase bit is a flop.
    logic in_fetch;
    logic fetch_done;

    assign in_fetch   = ctrl_q.mem_req & ~ctrl_q.iord;
    assign fetch_done = in_fetch & mem_ready & reset_n;

    // Enables are gated with reset_n so a request drops the moment reset
    // asserts and reappears in the first cycle after release.
    assign mem_req    = ctrl_q.mem_req & reset_n;
    assign mem_we     = ctrl_q.mem_we & reset_n;
    assign iord       = ctrl_q.iord;
    assign ir_write   = fetch_done;
    assign pc_write   = (ctrl_q.pc_write & reset_n) | fetch_done;
    assign branch     = ctrl_q.branch & reset_n;
    assign reg_write  = ctrl_q.reg_write & reset_n;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign wb_sel     = ctrl_q.wb_sel;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: random instruction streams with random
// memory waits, compared per cycle against a latency/phase model.
module tb_multi_cycle_controller;

    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_LW    = 7'b0000011;
    localparam logic [6:0] T_SW    = 7'b0100011;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults (EXT_J=1, MEM_TIMEOUT=16)
    logic       reset_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;

    // instance B: EXT_J=0, MEM_TIMEOUT=4
    logic       reset_n_b = 1'b0;
    logic [6:0] opcode_b = 7'd0;
    logic       mem_ready_b = 1'b0;
    logic       mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, branch_b, reg_write_b, trap_b;
    logic [1:0] alu_src_a_b, alu_src_b_b, alu_op_b, wb_sel_b, trap_cause_b;

    multi_cycle_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause)
    );

    multi_cycle_controller #(.EXT_J(1'b0), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .opcode(opcode_b), .mem_ready(mem_ready_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_write(ir_write_b),
        .pc_write(pc_write_b), .branch(branch_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .reg_write(reg_write_b),
        .wb_sel(wb_sel_b), .trap(trap_b), .trap_cause(trap_cause_b)
    );

    function automatic int classify(input logic [6:0] op);
        case (op)
            T_R:     return K_R;
            T_I:     return K_I;
            T_LW:    return K_LW;
            T_SW:    return K_SW;
            T_BR:    return K_BR;
            T_JAL:   return K_JAL;
            T_JALR:  return K_JALR;
            T_LUI:   return K_LUI;
            T_AUIPC: return K_AUIPC;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] op_by_index(input int i);
        case (i)
            0: return T_R;
            1: return T_I;
            2: return T_LW;
            3: return T_SW;
            4: return T_BR;
            5: return T_JAL;
            6: return T_JALR;
            7: return T_LUI;
            default: return T_AUIPC;
        endcase
    endfunction

    // {trap, mem_req, mem_we, iord, ir_write, pc_write, branch, reg_write}
    function automatic logic [7:0] vec_a();
        return {trap, mem_req, mem_we, iord, ir_write, pc_write, branch, reg_write};
    endfunction

    function automatic logic [7:0] vec_b();
        return {trap_b, mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, branch_b, reg_write_b};
    endfunction

    task automatic reset_a();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic reset_b();
        reset_n_b   = 1'b0;
        mem_ready_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n_b = 1'b1;
    endtask

    // Runs one instruction on instance A from its first FETCH cycle.
    // wf = wait cycles in FETCH, wm = wait cycles in MEM.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
        int cls, f, len, mem_lo, mem_hi, wb_c;
        bit is_mem;
        logic [7:0] exp_v, got_v;
        logic [5:0] exp_alu, mask_alu, got_alu;
        logic [1:0] exp_wb;
        cls    = classify(op);
        is_mem = (cls == K_LW || cls == K_SW);
        f      = wf + 1;
        mem_lo = f + 3;
        mem_hi = f + 3 + wm;
        if (cls == K_BR)      len = f + 2;
        else if (cls == K_LW) len = mem_hi + 1;
        else if (cls == K_SW) len = mem_hi;
        else                  len = f + 3;
        wb_c = (cls == K_BR || cls == K_SW) ? -1 : len;
        exp_wb = (cls == K_LW) ? 2'b01 : ((cls == K_JAL || cls == K_JALR) ? 2'b10 : 2'b00);

        for (int c = 1; c <= len; c++) begin
            opcode = op;
            if (c <= f)
                mem_ready = (c == f);
            else if (is_mem && c >= mem_lo && c <= mem_hi)
                mem_ready = (c == mem_hi);
            else
                mem_ready = 1'($urandom_range(0, 1));

            exp_v = 8'b0;
            if (c <= f) begin
                exp_v[6] = 1'b1;
                exp_v[3] = (c == f);
                exp_v[2] = (c == f);
            end
            if (c == f + 2) begin
                exp_v[2] = (cls == K_JAL || cls == K_JALR);
                exp_v[1] = (cls == K_BR);
            end
            if (is_mem && c >= mem_lo && c <= mem_hi) begin
                exp_v[6] = 1'b1;
                exp_v[5] = (cls == K_SW);
                exp_v[4] = 1'b1;
            end
            if (c == wb_c) exp_v[0] = 1'b1;

            @(negedge clk);
            got_v = vec_a();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL enables op=%b cycle=%0d got=%b expected=%b", op, c, got_v, exp_v);
            end
            if (c == wb_c) begin
                checks++;
                if (wb_sel !== exp_wb) begin
                    errors++;
                    $display("FAIL wb_sel op=%b cycle=%0d got=%b expected=%b", op, c, wb_sel, exp_wb);
                end
            end
            got_alu = {alu_src_a, alu_src_b, alu_op};
            if (c == 1) begin
                checks++;
                if (got_alu !== 6'b00_10_00) begin
                    errors++;
                    $display("FAIL fetch_alu op=%b got=%b expected=%b", op, got_alu, 6'b00_10_00);
                end
            end
            if (c == f + 2) begin
                // {src_a, src_b, op} with a mask for fields the class leaves open
                case (cls)
                    K_R:     begin exp_alu = 6'b00_00_10; mask_alu = 6'b00_11_11; end
                    K_I:     begin exp_alu = 6'b00_01_10; mask_alu = 6'b00_11_11; end
                    K_LW,
                    K_SW:    begin exp_alu = 6'b01_01_00; mask_alu = 6'b11_11_11; end
                    K_BR:    begin exp_alu = 6'b00_00_01; mask_alu = 6'b00_11_11; end
                    K_JAL:   begin exp_alu = 6'b00_01_00; mask_alu = 6'b11_11_11; end
                    K_JALR:  begin exp_alu = 6'b01_01_00; mask_alu = 6'b11_11_11; end
                    K_LUI:   begin exp_alu = 6'b10_01_00; mask_alu = 6'b11_11_00; end
                    default: begin exp_alu = 6'b00_01_00; mask_alu = 6'b11_11_00; end
                endcase
                checks++;
                if ((got_alu & mask_alu) !== exp_alu) begin
                    errors++;
                    $display("FAIL exec_alu op=%b got=%b expected=%b mask=%b", op, got_alu, exp_alu, mask_alu);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = T_R;
        @(negedge clk);
        checks++;
        if (vec_a() !== 8'b0 || trap_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got=%b cause=%b expected=00000000 cause=00", vec_a(), trap_cause);
        end
        @(posedge clk); #1;
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || iord !== 1'b0) begin
            errors++;
            $display("FAIL first_request got mem_req=%b iord=%b expected 1 0", mem_req, iord);
        end
    endtask

    task automatic test_add();
        run_instr(T_R, 0, 0);
        run_instr(T_I, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr(T_LW, 0, 3);
        run_instr(T_SW, 0, 0);
        run_instr(T_LW, 0, 0);
    endtask

    task automatic test_beq();
        run_instr(T_BR, 0, 0);
        run_instr(T_BR, 2, 0);
    endtask

    task automatic test_wait_boundary();
        run_instr(T_LW, 15, 15);
        run_instr(T_SW, 15, 15);
        run_instr(T_JAL, 15, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int wf, wm;
            wf = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 14));
            wm = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 14));
            run_instr(op_by_index(int'($urandom_range(0, 8))), wf, wm);
        end
    endtask

    task automatic test_reset_mid_sw();
        opcode = T_SW;
        for (int c = 1; c <= 4; c++) begin
            mem_ready = (c == 1) ? 1'b1 : ((c == 4) ? 1'b0 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
                    errors++;
                    $display("FAIL sw_mem_phase got mem_req=%b mem_we=%b expected 1 1", mem_req, mem_we);
                end
                reset_n = 1'b0;
                #1;
                checks++;
                if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_drop got mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_instr(T_SW, 1, 2);
        run_instr(T_R, 0, 0);
    endtask

    task automatic test_ext_j_disabled();
        logic [7:0] exp_v;
        reset_b();
        opcode_b = T_JAL;
        for (int c = 1; c <= 9; c++) begin
            mem_ready_b = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (c == 1)      exp_v = 8'b0100_1100;
            else if (c == 2) exp_v = 8'b0000_0000;
            else             exp_v = 8'b1000_0000;
            @(negedge clk);
            checks++;
            if (vec_b() !== exp_v || (c >= 3 && trap_cause_b !== 2'b01)) begin
                errors++;
                $display("FAIL illegal_jal cycle=%0d got=%b cause=%b expected=%b cause=01", c, vec_b(), trap_cause_b, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_v;
        // fetch never answered: four wait cycles, then trap
        reset_b();
        opcode_b = T_R;
        for (int c = 1; c <= 7; c++) begin
            mem_ready_b = (c >= 5) ? 1'b1 : 1'b0;
            exp_v = (c <= 4) ? 8'b0100_0000 : 8'b1000_0000;
            @(negedge clk);
            checks++;
            if (vec_b() !== exp_v || (c >= 5 && trap_cause_b !== 2'b10)) begin
                errors++;
                $display("FAIL fetch_timeout cycle=%0d got=%b cause=%b expected=%b cause=10", c, vec_b(), trap_cause_b, exp_v);
            end
            @(posedge clk); #1;
        end
        // ready on the last allowed cycle succeeds
        reset_b();
        opcode_b = T_R;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4)      mem_ready_b = (c == 4);
            else if (c == 8) mem_ready_b = 1'b0;
            else             mem_ready_b = 1'($urandom_range(0, 1));
            case (c)
                4:       exp_v = 8'b0100_1100;
                5, 6:    exp_v = 8'b0000_0000;
                7:       exp_v = 8'b0000_0001;
                default: exp_v = 8'b0100_0000;
            endcase
            @(negedge clk);
            checks++;
            if (vec_b() !== exp_v) begin
                errors++;
                $display("FAIL ready_at_limit cycle=%0d got=%b expected=%b", c, vec_b(), exp_v);
            end
            if (c == 1) begin
                checks++;
                if ({alu_src_a_b, alu_src_b_b, alu_op_b} !== 6'b00_10_00) begin
                    errors++;
                    $display("FAIL fetch_alu_b got=%b expected=001000", {alu_src_a_b, alu_src_b_b, alu_op_b});
                end
            end
            if (c == 6) begin
                checks++;
                if (alu_op_b !== 2'b10 || alu_src_b_b !== 2'b00) begin
                    errors++;
                    $display("FAIL exec_r_b got alu_op=%b src_b=%b expected 10 00", alu_op_b, alu_src_b_b);
                end
            end
            if (c == 7) begin
                checks++;
                if (wb_sel_b !== 2'b00) begin
                    errors++;
                    $display("FAIL wb_r_b got wb_sel=%b expected 00", wb_sel_b);
                end
            end
            @(posedge clk); #1;
        end
        // data access never answered: LW traps after four MEM cycles
        reset_b();
        opcode_b = T_LW;
        for (int c = 1; c <= 9; c++) begin
            if (c == 1)                 mem_ready_b = 1'b1;
            else if (c >= 4 && c <= 7)  mem_ready_b = 1'b0;
            else                        mem_ready_b = 1'($urandom_range(0, 1));
            case (c)
                1:             exp_v = 8'b0100_1100;
                2, 3:          exp_v = 8'b0000_0000;
                4, 5, 6, 7:    exp_v = 8'b0101_0000;
                default:       exp_v = 8'b1000_0000;
            endcase
            @(negedge clk);
            checks++;
            if (vec_b() !== exp_v || (c >= 8 && trap_cause_b !== 2'b10)) begin
                errors++;
                $display("FAIL mem_timeout cycle=%0d got=%b cause=%b expected=%b", c, vec_b(), trap_cause_b, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_wait_boundary();
        test_random();
        test_reset_mid_sw();
        test_ext_j_disabled();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter: EXT_J, default 1, enables JAL (1101111), JALR (1100111), LUI (0110111) and AUIPC (0010111); when 0 these opcodes are illegal.
REQ-002 Parameter: MEM_TIMEOUT, default 16, is the maximum number of cycles spent waiting on mem_ready; legal range 2..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  7  instruction[6:0]; valid from DECODE onward.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 mem_req  out  1  memory access request; held until mem_ready.
REQ-008 mem_we  out  1  write strobe, qualified by mem_req.
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 ir_write  out  1  load the instruction register (FETCH with mem_ready).
REQ-011 pc_write  out  1  unconditional PC update.
REQ-012 branch  out  1  PC update conditional on ALU zero (EXEC of BR).
REQ-013 alu_src_a  out  2  00 = PC, 01 = rs1, 10 = zero.
REQ-014 alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-015 alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-016 reg_write  out  1  register file write enable.
REQ-017 wb_sel  out  2  00 = ALU result, 01 = memory data, 10 = PC+4.
REQ-018 trap  out  1  sticky error flag.
REQ-019 trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.

Function
REQ-020 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-021 FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00. On mem_ready, assert ir_write and pc_write for one cycle, then go to DECODE.
REQ-022 DECODE: an illegal opcode goes to TRAP with cause 01; otherwise go to EXEC. Legal opcodes are R, I, LW, SW and BR, plus the EXT_J set when enabled.
REQ-023 EXEC for R and I: alu_op=10, alu_src_b=00 (R) or 01 (I), then WB.
REQ-024 EXEC for LW and SW: alu_op=00, alu_src_a=01, alu_src_b=01, then MEM.
REQ-025 EXEC for BR: alu_op=01, branch=1, alu_src_b=00, then FETCH.
REQ-026 EXEC for JAL and JALR: pc_write=1, target computed from PC+imm (JAL) or rs1+imm (JALR), then WB with wb_sel=10.
REQ-027 EXEC for LUI and AUIPC: alu_src_a=10 (LUI) or 00 (AUIPC), alu_src_b=01, then WB.
REQ-028 MEM: mem_req=1, iord=1, mem_we=1 only for SW. On mem_ready, LW goes to WB and SW goes to FETCH.
REQ-029 WB: reg_write=1 for exactly one cycle; wb_sel=01 for LW; then FETCH.
REQ-030 Latency with zero-wait memory: BR 3 cycles; R, I, SW, LUI, AUIPC, JAL and JALR 4 cycles; LW 5 cycles. Every wait cycle in FETCH or MEM adds one cycle.
REQ-031 A wait counter SHALL clear on entry to FETCH or MEM. If it reaches MEM_TIMEOUT without mem_ready, go to TRAP with cause 10 and drop mem_req.
REQ-032 mem_ready arriving in the same cycle the counter hits the limit SHALL count as success.
REQ-033 mem_ready outside FETCH and MEM SHALL be ignored.
REQ-034 TRAP is absorbing: all enables are 0, trap=1, and trap_cause is held until reset.
REQ-035 Outputs SHALL be Moore, decoded from the state and the registered opcode class; no enable may glitch across a state boundary.

Reset
REQ-036 reset_n low SHALL asynchronously force state FETCH, clear the wait counter, clear trap and trap_cause to 0, and drive every enable to 0 until reset is released.
REQ-037 Reset asserted mid-access SHALL drop mem_req immediately. The first request after release is issued in the first cycle with reset_n high.

Structure
REQ-038 The opcode constants, the state enum, and the alu_src/alu_op/wb_sel/trap_cause encodings SHALL live in the shared package riscv_ctrl_pkg.
REQ-039 A combinational sub-module opcode_class_decoder SHALL map opcode and EXT_J to a class enum plus a legal flag.

Verification
REQ-040 ADD with zero-wait memory: pc_write in cycle 1 and reg_write in cycle 4 with wb_sel=00; next fetch in cycle 5.
REQ-041 LW with 3 wait cycles in MEM: reg_write with wb_sel=01 exactly 1 cycle after mem_ready; total 8 cycles.
REQ-042 BEQ: branch=1 for one cycle in cycle 3 with alu_op=01; reg_write is never asserted.
REQ-043 EXT_J=0 with JAL opcode: trap=1 and trap_cause=01 in cycle 3; all enables stay 0 afterwards.
REQ-044 mem_ready held low in FETCH with MEM_TIMEOUT=4: trap_cause=10 after 4 cycles. A second run with mem_ready arriving exactly at cycle 4 SHALL proceed normally.
REQ-045 reset_n pulsed low during MEM of SW: mem_req drops combinationally, no mem_we follows, and the controller restarts in FETCH.
